// File: rtl/m_wb_uart.sv
// Wishbone-slave 8N1 UART: DATA/STATUS/DIV registers, one TX and one RX framer
// sharing a programmable bit-period divisor, single-cycle registered ACK.
module m_wb_uart #(
  parameter int unsigned DEFAULT_DIV = 104,
  parameter int unsigned MIN_DIV     = 8
) (
  input  logic        CLK_I,
  input  logic        RST_In,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        irq
);

  localparam logic [15:0] DEF_DIV_C = 16'(DEFAULT_DIV);
  localparam logic [15:0] MIN_DIV_C = 16'(MIN_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] div_q, div_d, div_merged_s;
  logic [31:0] rdata_s;
  logic        acc_s, wr_s, rd_s, tx_start_s, rd_data_s, w1c_s, div_wr_s;

  state_t      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_q, tx_d, tx_end_s;

  logic        sync1_q, sync2_q, rx_prev_q, rx_fall_s;
  state_t      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
  logic        rx_end_s, store_s, ferr_s;
  logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;

  // An access is the first cycle of a strobe; side effects land at its end.
  assign acc_s      = STB_I & ~ack_q;
  assign wr_s       = acc_s & WE_I;
  assign rd_s       = acc_s & ~WE_I;
  assign tx_start_s = wr_s & (ADR_I == 2'd0) & SEL_I[0] & (tx_state_q == S_IDLE);
  assign rd_data_s  = rd_s & (ADR_I == 2'd0);
  assign w1c_s      = wr_s & (ADR_I == 2'd1) & SEL_I[0];
  assign div_wr_s   = wr_s & (ADR_I == 2'd2) & (SEL_I[1:0] != 2'b00);

  always_comb begin
    div_merged_s = div_q;
    if (SEL_I[0]) div_merged_s[7:0]  = DAT_I[7:0];
    else          div_merged_s[7:0]  = div_q[7:0];
    if (SEL_I[1]) div_merged_s[15:8] = DAT_I[15:8];
    else          div_merged_s[15:8] = div_q[15:8];
    if (div_wr_s) div_d = (div_merged_s < MIN_DIV_C) ? MIN_DIV_C : div_merged_s;
    else          div_d = div_q;
  end

  always_comb begin
    case (ADR_I)
      2'd0:    rdata_s = {24'h000000, rx_byte_q};
      2'd1:    rdata_s = {28'h0000000, frame_err_q, overrun_q, rx_valid_q, tx_state_q != S_IDLE};
      2'd2:    rdata_s = {16'h0000, div_q};
      default: rdata_s = 32'h00000000;
    endcase
    ack_d = acc_s;
    dat_d = rd_s ? rdata_s : 32'h00000000;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_div_d   = tx_div_q;
    tx_end_s   = (tx_cnt_q == tx_div_q - 16'd1);
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = 16'd0;
        if (tx_start_s) begin
          tx_state_d = S_START;
          tx_byte_d  = DAT_I[7:0];
          tx_div_d   = div_q;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_end_s) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (tx_end_s) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tx_end_s) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = 16'd0;
        end else begin
          tx_state_d = S_STOP;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so usartTX itself is a flop.
  always_comb begin
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_byte_d[tx_bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign rx_fall_s = rx_prev_q & ~sync2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_div_d   = rx_div_q;
    if (rx_state_q == S_START) rx_end_s = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
    else                       rx_end_s = (rx_cnt_q == rx_div_q - 16'd1);
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_fall_s) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_end_s) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (rx_end_s) begin
          rx_cnt_d = 16'd0;
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (rx_end_s) rx_state_d = S_IDLE;
        else          rx_state_d = S_STOP;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    store_s = (rx_state_q == S_STOP) & rx_end_s & sync2_q;
    ferr_s  = (rx_state_q == S_STOP) & rx_end_s & ~sync2_q;
  end

  // Flag sets take priority over the bus clearing them in the same cycle.
  always_comb begin
    rx_byte_d = store_s ? rx_sh_q : rx_byte_q;
    if (store_s)        rx_valid_d = 1'b1;
    else if (rd_data_s) rx_valid_d = 1'b0;
    else                rx_valid_d = rx_valid_q;
    if (store_s & rx_valid_q & ~rd_data_s) overrun_d = 1'b1;
    else if (w1c_s & DAT_I[2])             overrun_d = 1'b0;
    else                                   overrun_d = overrun_q;
    if (ferr_s)                 frame_err_d = 1'b1;
    else if (w1c_s & DAT_I[3])  frame_err_d = 1'b0;
    else                        frame_err_d = frame_err_q;
  end

  always_ff @(posedge CLK_I or negedge RST_In) begin
    if (!RST_In) begin
      ack_q <= 1'b0;  dat_q <= 32'h00000000;  div_q <= DEF_DIV_C;
      tx_state_q <= S_IDLE;  tx_cnt_q <= 16'd0;  tx_bit_q <= 3'd0;
      tx_byte_q <= 8'h00;  tx_div_q <= DEF_DIV_C;  tx_q <= 1'b1;
      sync1_q <= 1'b1;  sync2_q <= 1'b1;  rx_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;  rx_cnt_q <= 16'd0;  rx_bit_q <= 3'd0;
      rx_sh_q <= 8'h00;  rx_div_q <= DEF_DIV_C;  rx_byte_q <= 8'h00;
      rx_valid_q <= 1'b0;  overrun_q <= 1'b0;  frame_err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;  dat_q <= dat_d;  div_q <= div_d;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;
      tx_byte_q <= tx_byte_d;  tx_div_q <= tx_div_d;  tx_q <= tx_d;
      sync1_q <= usartRX;  sync2_q <= sync1_q;  rx_prev_q <= sync2_q;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;  rx_div_q <= rx_div_d;  rx_byte_q <= rx_byte_d;
      rx_valid_q <= rx_valid_d;  overrun_q <= overrun_d;  frame_err_q <= frame_err_d;
    end
  end

  assign ACK_O   = ack_q;
  assign DAT_O   = dat_q;
  assign usartTX = tx_q;
  assign irq     = rx_valid_q;

endmodule

// File: doc/m_wb_uart.md
# m_wb_uart

Wishbone-slave UART controller for the midgetv iCE40 boards. It replaces the bit-banged `usartTX` output and the polled `usartRX` input with hardware framing. The TX and RX state machines each serialise or deserialise one 8N1 byte at a programmable baud divisor. It sits on the core's `STB_O`/`WE_O`/`ADR_O`/`SEL_O`/`DAT_O` bus beside the LED register and returns a single-cycle registered ACK.

## Interface
- `DEFAULT_DIV`, 104: reset value of the bit-period divisor, in clocks (12 MHz / 115200).
- `MIN_DIV`, 8: smallest accepted divisor. Writes below this saturate to `MIN_DIV`.
- `CLK_I  in  1`: single clock, rising edge.
- `RST_In  in  1`: reset, asynchronous, active-low.
- `STB_I  in  1`: bus strobe, already address-qualified by the top level.
- `WE_I  in  1`: write enable.
- `ADR_I  in  2`: register select, connected to core `ADR_O[3:2]`.
- `SEL_I  in  4`: byte lanes. Only `SEL_I[0]` gates writes to regs 0 and 1; `SEL_I[1:0]` gate reg 2.
- `DAT_I  in  32`: write data.
- `DAT_O  out  32`: read data. Valid only while `ACK_O=1`, otherwise 0.
- `ACK_O  out  1`: bus acknowledge.
- `usartRX  in  1`: asynchronous serial input.
- `usartTX  out  1`: serial output, registered.
- `irq  out  1`: level, equal to `rx_valid`.

## Operation
- **Registers**
  - Reg 0, DATA. Write `[7:0]` starts a TX frame if `tx_busy=0`; the write is silently dropped if busy. Read returns `{24'h0, rx_byte}` and clears `rx_valid`.
  - Reg 1, STATUS. Bit 0 `tx_busy`, bit 1 `rx_valid`, bit 2 `overrun`, bit 3 `frame_err`. Writing 1 to bit 2 or bit 3 clears that bit (W1C). Other bits read 0.
  - Reg 2, DIV. `[15:0]` holds the divisor.
  - Reg 3 reads 0; writes to it are ignored.
- **Bus access:** an access is the cycle where `STB_I & ~ACK_O`. All side effects (TX start, `rx_valid` clear, W1C, DIV update) occur at the end of that cycle.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - The divisor is latched at frame start.
  - Each state holds the line for exactly `div` clocks. DATA sends bits LSB first, using a 3-bit bit counter.
  - STOP drives 1. At the end of STOP the FSM returns to IDLE and clears `tx_busy`.
- **RX input:** `usartRX` passes through a 2-FF synchroniser.
- **RX FSM states:** IDLE, START, DATA, STOP. The divisor is latched on the falling edge.
  - IDLE: a synced 1→0 transition moves to START.
  - START: waits `div>>1` clocks, then samples. A sample of 1 is a false start and returns to IDLE with no flags. A sample of 0 goes to DATA.
  - DATA: samples 8 bits, one every `div` clocks, shifted in LSB first.
  - STOP: samples after `div` clocks.
    - Sample 1: the byte is stored into `rx_byte` and `rx_valid` is set. If `rx_valid` was already 1, the old byte is overwritten and `overrun` is set.
    - Sample 0: `frame_err` is set, and the byte is discarded.
  - After the STOP sample the FSM returns to IDLE immediately, without waiting for the remainder of the stop bit.
- **Simultaneous events:**
  - A byte stored in the same cycle as a DATA read: the new byte wins, and `rx_valid` stays 1 with no overrun.
  - A set and a W1C of a flag in the same cycle: the set wins.
- **DIV write during a frame:** affects only later frames.

## Timing
- **Reset values:** `usartTX=1`, `ACK_O=0`, `DAT_O=0`, `irq=0`. All flags are 0, `div=DEFAULT_DIV`, both FSMs are in IDLE, and the synchroniser FFs are 1.
- **ACK:** `ACK_O` rises in the cycle after the access and lasts 1 cycle (`ACK_O <= STB_I & ~ACK_O`). A held `STB_I` therefore gets one ACK every 2 cycles. Dropping `STB_I` during the ACK cycle is legal.
- **TX latency:** for a write accepted in cycle t:
  - `tx_busy=1` and `usartTX=0` from t+1.
  - Data bit k is driven from t+1+(k+1)·div.
  - The stop bit is driven from t+1+9·div.
  - `tx_busy=0` at t+1+10·div.
- **RX latency:** for a falling edge on the pin at cycle e:
  - The synced edge is seen at e+2.
  - The START sample is taken at e+2+div/2.
  - `rx_valid` rises at e+3+div/2+9·div (±1 clock).
- **Async reset mid-frame:** `usartTX` returns to 1 immediately. A partial RX byte is discarded with no flags raised.

## Test plan
- **Reset:** assert `RST_In=0` mid-TX at an arbitrary cycle → `usartTX=1` combinationally. After release, a STATUS read returns 0 and a DIV read returns 104.
- **TX frame:** DIV=8, write DATA=0xA5 → `usartTX` shows 0,1,0,1,0,0,1,0,1,1, each level held 8 clocks. `tx_busy` stays 1 for 80 clocks. A second write of 0x3C during the frame is dropped and produces no second frame.
- **RX good byte:** drive 0x5A at div=8 → `rx_valid=1` and `irq=1`. A DATA read returns 0x0000005A, after which `rx_valid=0`.
- **RX overrun, then W1C:** receive 0x11 then 0x22 without reading → `overrun=1` and DATA=0x22. Write STATUS=0x4 → `overrun=0`.
- **Frame error and false start:** receive 0x77 with the stop bit forced to 0 → `frame_err=1` and `rx_valid` unchanged. A 2-clock low glitch on the pin → no flags, and the FSM returns to IDLE.
- **Bus:** hold `STB_I` for 6 cycles on a STATUS read → exactly 3 ACK pulses, with `DAT_O=0` outside ACK cycles. Writing DIV=3 reads back 8.
